axi_mem_arbiter: RTL and testbench

- Shares the single cache-line AXI burst port (AXI_M side) between the instruction cache and the data cache.
- Sits inside `top`, between the two cache FSMs and the `o_start_*_axi` / `i_*_axi` ports of `top`.
- Grants one transaction at a time and holds the grant until completion.
- Latches address/data so requesters may change inputs after grant; routes completion only to the granted requester.

---
 rtl/axi_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 23 ++
 rtl/axi_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_axi_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types for the I-cache / D-cache AXI line-port arbiter.
// State encoding, requester identifiers and the grant code on the debug port.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_IC,
    RD_DC,
    WR_DC,
    DONE
  } t_arb_state;

  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_IC   = 2'b01,
    REQ_DC   = 2'b10
  } t_req_id;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between I-cache and D-cache requests.
// When both requesters are pending, the one that was not granted last time wins.
module rr_arb2
  import axi_arb_pkg::*;
(
  input  logic    ic_req,
  input  logic    dc_req,
  input  t_req_id rr_last,
  output t_req_id pick
);

  always_comb begin
    pick = REQ_NONE;
    if (ic_req && dc_req) begin
      pick = (rr_last == REQ_IC) ? REQ_DC : REQ_IC;
    end else if (ic_req) begin
      pick = REQ_IC;
    end else if (dc_req) begin
      pick = REQ_DC;
    end
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one cache-line AXI burst port between the I-cache and the D-cache.
// One transaction at a time; address/write line are latched at grant.
module axi_mem_arbiter
  import axi_arb_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int DATA_WIDTH     = 512
) (
  input  logic                      clk,
  input  logic                      arstn,
  input  logic                      i_ic_start_read,
  input  logic [AXI_ADDR_WIDTH-1:0] i_ic_addr,
  output logic [DATA_WIDTH-1:0]     o_ic_data,
  output logic                      o_ic_read_last,
  input  logic                      i_dc_start_read,
  input  logic                      i_dc_start_write,
  input  logic [AXI_ADDR_WIDTH-1:0] i_dc_addr,
  input  logic [DATA_WIDTH-1:0]     i_dc_data_write,
  output logic [DATA_WIDTH-1:0]     o_dc_data,
  output logic                      o_dc_read_last,
  output logic                      o_dc_b_resp,
  output logic                      o_start_read_axi,
  output logic                      o_start_write_axi,
  output logic [AXI_ADDR_WIDTH-1:0] o_addr_axi,
  output logic [DATA_WIDTH-1:0]     o_data_write_axi,
  input  logic [DATA_WIDTH-1:0]     i_data_read_axi,
  input  logic                      i_read_last_axi,
  input  logic                      i_b_resp_axi,
  output logic [1:0]                o_grant,
  output t_arb_state                o_state
);

  // Handshake: requests are levels held until their completion pulse; the
  // arbiter samples them only in IDLE, drives o_start_* from registered state
  // until i_read_last_axi / i_b_resp_axi, then spends one DONE cycle ignoring
  // completions so the requester can drop its start.

  t_arb_state                state;
  t_arb_state                state_nxt;
  t_req_id                   rr_last;
  t_req_id                   pick;
  logic                      ic_req;
  logic                      dc_req;
  logic                      grant;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;

  assign ic_req = i_ic_start_read;
  assign dc_req = i_dc_start_read | i_dc_start_write;

  rr_arb2 u_rr_arb2 (
    .ic_req  (ic_req),
    .dc_req  (dc_req),
    .rr_last (rr_last),
    .pick    (pick)
  );

  assign grant = (state == IDLE) && (pick != REQ_NONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        case (pick)
          REQ_IC:  state_nxt = RD_IC;
          // Writeback goes before the refill when both are raised together.
          REQ_DC:  state_nxt = i_dc_start_write ? WR_DC : RD_DC;
          default: state_nxt = IDLE;
        endcase
      end
      RD_IC, RD_DC: if (i_read_last_axi) state_nxt = DONE;
      WR_DC:        if (i_b_resp_axi) state_nxt = DONE;
      DONE:         state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state   <= IDLE;
      rr_last <= REQ_DC;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        rr_last <= pick;
        addr_q  <= (pick == REQ_IC) ? i_ic_addr : i_dc_addr;
        if ((pick == REQ_DC) && i_dc_start_write) begin
          wdata_q <= i_dc_data_write;
        end
      end
    end
  end

  assign o_start_read_axi  = (state == RD_IC) || (state == RD_DC);
  assign o_start_write_axi = (state == WR_DC);
  assign o_addr_axi        = addr_q;
  assign o_data_write_axi  = wdata_q;

  // Completion is forwarded only to the owner of the current state.
  assign o_ic_read_last = (state == RD_IC) && i_read_last_axi;
  assign o_dc_read_last = (state == RD_DC) && i_read_last_axi;
  assign o_dc_b_resp    = (state == WR_DC) && i_b_resp_axi;

  assign o_ic_data = i_data_read_axi;
  assign o_dc_data = i_data_read_axi;

  always_comb begin
    o_grant = REQ_NONE;
    case (state)
      RD_IC:        o_grant = REQ_IC;
      RD_DC, WR_DC: o_grant = REQ_DC;
      default:      o_grant = REQ_NONE;
    endcase
  end

  assign o_state = state;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: grant order, latching, response routing,
// spurious completions and asynchronous reset, checked against a start queue.
module tb_axi_mem_arbiter;
  import axi_arb_pkg::*;

  localparam int AW = 64;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          arstn;
  logic          i_ic_start_read;
  logic [AW-1:0] i_ic_addr;
  logic [DW-1:0] o_ic_data;
  logic          o_ic_read_last;
  logic          i_dc_start_read;
  logic          i_dc_start_write;
  logic [AW-1:0] i_dc_addr;
  logic [DW-1:0] i_dc_data_write;
  logic [DW-1:0] o_dc_data;
  logic          o_dc_read_last;
  logic          o_dc_b_resp;
  logic          o_start_read_axi;
  logic          o_start_write_axi;
  logic [AW-1:0] o_addr_axi;
  logic [DW-1:0] o_data_write_axi;
  logic [DW-1:0] i_data_read_axi;
  logic          i_read_last_axi;
  logic          i_b_resp_axi;
  logic [1:0]    o_grant;
  t_arb_state    o_state;

  // Scoreboard entry: {kind, addr}; kind 01 = I read, 10 = D read, 11 = D write.
  logic [AW+1:0] exp_q[$];
  logic [1:0]    cur_kind;
  int            n_checks = 0;
  int            n_err    = 0;
  int            gap;
  logic [DW-1:0] ones;

  axi_mem_arbiter u_dut (
    .clk               (clk),
    .arstn             (arstn),
    .i_ic_start_read   (i_ic_start_read),
    .i_ic_addr         (i_ic_addr),
    .o_ic_data         (o_ic_data),
    .o_ic_read_last    (o_ic_read_last),
    .i_dc_start_read   (i_dc_start_read),
    .i_dc_start_write  (i_dc_start_write),
    .i_dc_addr         (i_dc_addr),
    .i_dc_data_write   (i_dc_data_write),
    .o_dc_data         (o_dc_data),
    .o_dc_read_last    (o_dc_read_last),
    .o_dc_b_resp       (o_dc_b_resp),
    .o_start_read_axi  (o_start_read_axi),
    .o_start_write_axi (o_start_write_axi),
    .o_addr_axi        (o_addr_axi),
    .o_data_write_axi  (o_data_write_axi),
    .i_data_read_axi   (i_data_read_axi),
    .i_read_last_axi   (i_read_last_axi),
    .i_b_resp_axi      (i_b_resp_axi),
    .o_grant           (o_grant),
    .o_state           (o_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i_ic_start_read  = 1'b0;
    i_ic_addr        = '0;
    i_dc_start_read  = 1'b0;
    i_dc_start_write = 1'b0;
    i_dc_addr        = '0;
    i_dc_data_write  = '0;
    i_data_read_axi  = '0;
    i_read_last_axi  = 1'b0;
    i_b_resp_axi     = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start_rd"}, o_start_read_axi, 0);
    chk({tag, "_start_wr"}, o_start_write_axi, 0);
    chk({tag, "_grant"}, o_grant, 0);
    chk({tag, "_addr"}, o_addr_axi, 0);
    chk({tag, "_wdata"}, o_data_write_axi, 0);
    chk({tag, "_resp"}, {o_ic_read_last, o_dc_read_last, o_dc_b_resp}, 0);
    chk({tag, "_state"}, o_state, IDLE);
  endtask

  // Wait (bounded) for a start, then pop the scoreboard and compare kind/addr.
  task automatic sb_pop_start(output int waited);
    logic [AW+1:0] e;
    logic [1:0]    kind;
    waited = 0;
    while (!(o_start_read_axi || o_start_write_axi) && waited < 12) begin
      step();
      waited++;
    end
    chk("start_seen", o_start_read_axi | o_start_write_axi, 1);
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      kind = o_start_write_axi ? 2'b11 : o_grant;
      chk("start_kind", kind, e[AW+1:AW]);
      chk("start_addr", o_addr_axi, e[AW-1:0]);
      cur_kind = e[AW+1:AW];
    end
  endtask

  // Complete the current transaction after a random delay; returns in DONE.
  task automatic finish_txn();
    logic [DW-1:0] rdata;
    rdata = {16{$urandom()}};
    repeat ($urandom_range(1, 4)) step();
    if (cur_kind == 2'b11) begin
      i_b_resp_axi = 1'b1;
    end else begin
      i_read_last_axi = 1'b1;
      i_data_read_axi = rdata;
    end
    #1;
    chk("ic_last", o_ic_read_last, cur_kind == 2'b01);
    chk("dc_last", o_dc_read_last, cur_kind == 2'b10);
    chk("dc_bresp", o_dc_b_resp, cur_kind == 2'b11);
    if (cur_kind == 2'b01) chk("ic_data", o_ic_data, rdata);
    if (cur_kind == 2'b10) chk("dc_data", o_dc_data, rdata);
    step();
    chk("done_start", o_start_read_axi | o_start_write_axi, 0);
    chk("done_grant", o_grant, 0);
    chk("done_resp", {o_ic_read_last, o_dc_read_last, o_dc_b_resp}, 0);
    i_read_last_axi = 1'b0;
    i_b_resp_axi    = 1'b0;
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    idle_inputs();
    #1;
    chk_all_zero("rst");
    step();
    step();
    arstn = 1'b1;
    step();
  endtask

  initial begin
    ones = '1;
    arstn = 1'b1;
    idle_inputs();
    #2;
    do_reset();

    // I-cache only: start one cycle after request, completion at cycle 20.
    i_ic_start_read = 1'b1;
    i_ic_addr       = 64'h1000;
    exp_q.push_back({2'b01, 64'h1000});
    #1;
    chk("t1_no_comb_start", o_start_read_axi, 0);
    sb_pop_start(gap);
    chk("t1_latency", gap, 1);
    repeat (19) step();
    i_read_last_axi = 1'b1;
    i_data_read_axi = {16{32'hA5A5_0001}};
    #1;
    chk("t1_ic_last", o_ic_read_last, 1);
    chk("t1_dc_last", o_dc_read_last, 0);
    chk("t1_ic_data", o_ic_data, {16{32'hA5A5_0001}});
    step();
    chk("t1_start_off", o_start_read_axi, 0);
    chk("t1_done_ignore", o_ic_read_last, 0);
    i_read_last_axi = 1'b0;
    i_ic_start_read = 1'b0;
    step();

    // Both reads after reset: I first, then alternate while both held.
    do_reset();
    i_ic_start_read = 1'b1;
    i_ic_addr       = 64'h3000;
    i_dc_start_read = 1'b1;
    i_dc_addr       = 64'h4000;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_q.push_back({2'b01, 64'h3000});
      else            exp_q.push_back({2'b10, 64'h4000});
      sb_pop_start(gap);
      if (i > 0) chk("t2_gap_after_done", gap, 2);
      finish_txn();
    end
    i_ic_start_read = 1'b0;
    i_dc_start_read = 1'b0;
    step();

    // D read+write together: writeback first, latched address and line.
    i_dc_start_read  = 1'b1;
    i_dc_start_write = 1'b1;
    i_dc_addr        = 64'h2040;
    i_dc_data_write  = ones;
    exp_q.push_back({2'b11, 64'h2040});
    sb_pop_start(gap);
    i_dc_addr       = '0;
    i_dc_data_write = '0;
    chk("t3_wdata", o_data_write_axi, ones);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_addr_held", o_addr_axi, 64'h2040);
    end
    i_read_last_axi = 1'b1;
    #1;
    chk("t3_spur_rl_resp", {o_ic_read_last, o_dc_read_last, o_dc_b_resp}, 0);
    step();
    chk("t3_spur_rl_state", o_state, WR_DC);
    chk("t3_still_writing", o_start_write_axi, 1);
    i_read_last_axi = 1'b0;
    finish_txn();
    i_dc_start_write = 1'b0;
    exp_q.push_back({2'b10, 64'h0});
    sb_pop_start(gap);
    finish_txn();
    i_dc_start_read = 1'b0;
    step();

    // Spurious completions in IDLE.
    i_read_last_axi = 1'b1;
    i_b_resp_axi    = 1'b1;
    #1;
    chk("t4_idle_resp", {o_ic_read_last, o_dc_read_last, o_dc_b_resp}, 0);
    step();
    chk("t4_idle_state", o_state, IDLE);
    chk("t4_idle_start", o_start_read_axi | o_start_write_axi, 0);
    i_read_last_axi = 1'b0;
    i_b_resp_axi    = 1'b0;

    // Asynchronous reset in the middle of a D-cache read.
    i_dc_start_read = 1'b1;
    i_dc_addr       = 64'h5000;
    exp_q.push_back({2'b10, 64'h5000});
    sb_pop_start(gap);
    step();
    step();
    do_reset();
    i_ic_start_read = 1'b1;
    i_ic_addr       = 64'h6000;
    exp_q.push_back({2'b01, 64'h6000});
    sb_pop_start(gap);
    chk("t5_regrant_latency", gap, 1);
    finish_txn();
    i_ic_start_read = 1'b0;
    step();
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
